beat_sequencer: RTL and testbench

BEAT_SEQUENCER -- requirements
Module: beat_sequencer

---
 rtl/beat_sequencer.sv | 84 ++++++++
 tb/tb_beat_sequencer.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/beat_sequencer.sv
// beat_sequencer: lub-dub heartbeat LED sequencer with error-code blink overlay.
module beat_sequencer #(
    parameter int TICK_W      = 8,
    parameter int PULSE_TICKS = 2,
    parameter int GAP_TICKS   = 1,
    parameter int REST_TICKS  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       enable,
    input  logic       err_req,
    input  logic [3:0] err_code,
    output logic       led,
    output logic [2:0] phase,
    output logic       err_ack,
    output logic       err_busy,
    output logic       beat_done
);
    typedef enum logic [2:0] {OFF, LUB, GAP, DUB, REST, ERR_ON, ERR_OFF, ERR_REST} state_t;
    state_t state, state_n;
    logic [TICK_W-1:0] tcnt, tcnt_n, len;
    logic [3:0] blink_cnt, blink_n;
    logic ack_n, done_n, accept, last;
    always_comb begin
        len = (state == GAP || state == ERR_OFF) ? TICK_W'(GAP_TICKS) :
              (state == REST || state == ERR_REST) ? TICK_W'(REST_TICKS) : TICK_W'(PULSE_TICKS);
        accept = enable && err_req && err_code != 4'd0 && state inside {LUB, GAP, DUB, REST};
        last = tick && tcnt == len - TICK_W'(1);
    end
    // Priority: disable > error acceptance > leaving OFF > tick-driven advance.
    always_comb begin
        state_n = state;
        tcnt_n  = tcnt;
        blink_n = blink_cnt;
        ack_n   = 1'b0;
        done_n  = 1'b0;
        if (!enable) begin
            state_n = OFF;
            tcnt_n  = '0;
            blink_n = 4'd0;
        end else if (accept) begin
            state_n = ERR_ON;
            tcnt_n  = '0;
            blink_n = err_code;
            ack_n   = 1'b1;
        end else if (state == OFF) begin
            state_n = LUB;
            tcnt_n  = '0;
        end else if (last) begin
            tcnt_n = '0;
            case (state)
                LUB:      state_n = GAP;
                GAP:      state_n = DUB;
                DUB:      state_n = REST;
                REST:     begin state_n = LUB; done_n = 1'b1; end
                ERR_ON:   begin state_n = ERR_OFF; blink_n = blink_cnt - 4'd1; end
                ERR_OFF:  state_n = (blink_cnt == 4'd0) ? ERR_REST : ERR_ON;
                ERR_REST: state_n = LUB;
                default:  state_n = OFF;
            endcase
        end else if (tick) begin
            tcnt_n = tcnt + TICK_W'(1);
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= OFF;
            tcnt      <= '0;
            blink_cnt <= 4'd0;
            err_ack   <= 1'b0;
            beat_done <= 1'b0;
        end else begin
            state     <= state_n;
            tcnt      <= tcnt_n;
            blink_cnt <= blink_n;
            err_ack   <= ack_n;
            beat_done <= done_n;
        end
    end
    assign led      = state inside {LUB, DUB, ERR_ON};
    assign phase    = state;
    assign err_busy = state inside {ERR_ON, ERR_OFF, ERR_REST};
endmodule

// File: tb/tb_beat_sequencer.sv
// tb_beat_sequencer: directed scenarios plus random traffic against a phase/elapsed-tick reference model.
module tb_beat_sequencer;
    localparam int PULSE = 2, GAP = 1, REST = 4;
    logic clk = 1'b0, reset = 1'b1, tick = 1'b1, enable = 1'b1, err_req = 1'b0;
    logic [3:0] err_code = 4'd0;
    logic led, err_ack, err_busy, beat_done;
    logic [2:0] phase;
    int checks = 0, errors = 0;
    int mph = 0, mel = 0, mbl = 0, mack = 0, mbd = 0;
    int pat1 [9]  = '{1, 1, 0, 1, 1, 0, 0, 0, 0};
    int pat2 [13] = '{1, 1, 0, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0};

    beat_sequencer #(.TICK_W(8), .PULSE_TICKS(PULSE), .GAP_TICKS(GAP), .REST_TICKS(REST)) dut (
        .clk(clk), .reset(reset), .tick(tick), .enable(enable), .err_req(err_req),
        .err_code(err_code), .led(led), .phase(phase), .err_ack(err_ack),
        .err_busy(err_busy), .beat_done(beat_done)
    );

    always #5 clk = ~clk;

    function automatic int len_of(int p);
        return (p == 2 || p == 6) ? GAP : (p == 4 || p == 7) ? REST : PULSE;
    endfunction

    // Model: phase number, ticks elapsed in it, blinks still owed.
    always @(posedge clk) begin
        mack = 0;
        mbd  = 0;
        if (reset || !enable) begin
            mph = 0; mel = 0; mbl = 0;
        end else if (err_req && err_code != 0 && mph >= 1 && mph <= 4) begin
            mph = 5; mel = 0; mbl = int'(err_code); mack = 1;
        end else if (mph == 0) begin
            mph = 1; mel = 0;
        end else if (tick) begin
            mel++;
            if (mel == len_of(mph)) begin
                mel = 0;
                if (mph == 4) begin mph = 1; mbd = 1; end
                else if (mph < 4) mph++;
                else if (mph == 5) begin mph = 6; mbl--; end
                else if (mph == 6) mph = (mbl == 0) ? 7 : 5;
                else mph = 1;
            end
        end
    end

    always @(negedge clk) begin
        int eled, ebusy;
        eled  = (mph == 1 || mph == 3 || mph == 5) ? 1 : 0;
        ebusy = (mph >= 5) ? 1 : 0;
        checks++;
        if (int'(phase) != mph || int'(led) != eled || int'(err_ack) != mack ||
            int'(err_busy) != ebusy || int'(beat_done) != mbd) begin
            errors++;
            $display("FAIL model t=%0t phase/led/ack/busy/done got %0d/%0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d/%0d",
                     $time, phase, led, err_ack, err_busy, beat_done, mph, eled, mack, ebusy, mbd);
        end
    end

    task automatic lit(string name, int got, int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_phase(int p);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (int'(phase) == p) return;
        end
        lit("wait_phase", int'(phase), p);
    endtask

    initial begin
        cyc();
        cyc();
        @(negedge clk);
        lit("reset_phase", int'(phase), 0);
        lit("reset_led", int'(led), 0);
        lit("reset_ack", int'(err_ack), 0);
        cyc();
        reset = 1'b0;
        @(posedge clk);
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            lit("beat_led", int'(led), pat1[i % 9]);
            lit("beat_done", int'(beat_done), (i == 9) ? 1 : 0);
        end
        wait_phase(2);
        err_req = 1'b1; err_code = 4'd0;
        @(negedge clk);
        err_req = 1'b0;
        lit("code0_ack", int'(err_ack), 0);
        wait_phase(4);
        err_req = 1'b1; err_code = 4'd3;
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            lit("err_led", int'(led), pat2[i]);
            lit("err_busy", int'(err_busy), 1);
            lit("err_ack", int'(err_ack), (i == 0) ? 1 : 0);
            err_req = (i == 2);
            err_code = (i == 2) ? 4'd5 : 4'd0;
        end
        @(negedge clk);
        lit("err_return_phase", int'(phase), 1);
        lit("err_return_done", int'(beat_done), 0);
        wait_phase(3);
        tick = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lit("hold_phase", int'(phase), 3);
            lit("hold_led", int'(led), 1);
        end
        tick = 1'b1;
        wait_phase(1);
        err_req = 1'b1; err_code = 4'd2;
        @(negedge clk);
        err_req = 1'b0;
        lit("abort_phase_on", int'(phase), 5);
        enable = 1'b0;
        @(negedge clk);
        lit("abort_phase", int'(phase), 0);
        lit("abort_busy", int'(err_busy), 0);
        enable = 1'b1;
        @(negedge clk);
        lit("reen_lub0", int'(phase), 1);
        @(negedge clk);
        lit("reen_lub1", int'(phase), 1);
        @(negedge clk);
        lit("reen_gap", int'(phase), 2);
        err_req = 1'b1; err_code = 4'd4;
        @(negedge clk);
        err_req = 1'b0;
        wait_phase(6);
        reset = 1'b1; err_req = 1'b1; err_code = 4'd7;
        cyc();
        reset = 1'b0; err_req = 1'b0;
        @(negedge clk);
        lit("rst_phase", int'(phase), 0);
        lit("rst_outs", int'({led, err_ack, err_busy, beat_done}), 0);
        @(negedge clk);
        lit("rst_lub", int'(phase), 1);
        for (int i = 0; i < 2000; i++) begin
            cyc();
            tick     = $urandom_range(0, 1) == 1;
            enable   = $urandom_range(0, 19) != 0;
            err_req  = $urandom_range(0, 9) == 0;
            err_code = 4'($urandom_range(0, 15));
            reset    = $urandom_range(0, 99) == 0;
        end
        cyc();
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
